sap_u_control_unit: RTL and testbench

Microcoded sequencer for the SAP-U datapath: register A, register B, ALU, RAM with MAR, and the shared 8-bit bus. The block holds the program counter, the instruction register and a T-state counter. Each clock it drives exactly the load and enable strobes that the datapath control inputs expect. It runs fetch (T0-T1) followed by an opcode-specific execute phase (T2-T4) with early return to T0, and halts on HLT.

---
 rtl/sap_u_control_unit_if.sv | 42 ++++
 rtl/sap_u_control_unit.sv | 161 ++++++++++++++++
 tb/tb_sap_u_control_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_u_control_unit_if.sv
// Control bus between the SAP-U sequencer and its datapath.
// master: the sequencer (samples run/bus_in and drives the strobes).
// slave: the datapath side (drives run/bus_in and samples the strobes).
interface sap_u_control_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  run;
  logic [DATA_WIDTH-1:0] bus_in;

  logic                  pc_bus_enable;
  logic [DATA_WIDTH-1:0] pc_bus_data;
  logic                  ir_operand_enable;
  logic [DATA_WIDTH-1:0] ir_operand_data;
  logic                  ram_load_mar_reg;
  logic                  ram_output_enable;
  logic                  ram_write_enable;
  logic                  reg_a_load;
  logic                  reg_a_enable;
  logic                  reg_b_load;
  logic                  alu_enable;
  logic                  alu_subtract;
  logic                  out_load;
  logic [3:0]            opcode;
  logic [2:0]            t_state;
  logic                  halted;

  modport master (
    input  run, bus_in,
    output pc_bus_enable, pc_bus_data, ir_operand_enable, ir_operand_data,
           ram_load_mar_reg, ram_output_enable, ram_write_enable,
           reg_a_load, reg_a_enable, reg_b_load, alu_enable, alu_subtract,
           out_load, opcode, t_state, halted
  );

  modport slave (
    output run, bus_in,
    input  pc_bus_enable, pc_bus_data, ir_operand_enable, ir_operand_data,
           ram_load_mar_reg, ram_output_enable, ram_write_enable,
           reg_a_load, reg_a_enable, reg_b_load, alu_enable, alu_subtract,
           out_load, opcode, t_state, halted
  );
endinterface

// File: rtl/sap_u_control_unit.sv
// SAP-U microcoded sequencer: PC, IR and T-state counter.
// Fetch in T0-T1, opcode-specific execute in T2-T4, early return to T0,
// and a sticky HALT that only reset clears.
module sap_u_control_unit #(
  parameter int PC_WIDTH   = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sap_u_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } op_t;

  tstate_t               state, state_next;
  logic [PC_WIDTH-1:0]   pc, pc_next;
  logic [DATA_WIDTH-1:0] ir, ir_next;
  logic                  halted_q, halted_next;
  op_t                   op;
  logic                  strobe_en;

  assign op        = op_t'(ir[7:4]);
  assign strobe_en = bus.run && reset && !halted_q;

  // State register: synchronous active-low reset, otherwise take next values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= T0;
      pc       <= '0;
      ir       <= '0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      ir       <= ir_next;
      halted_q <= halted_next;
    end
  end

  // Next-state logic: everything holds unless running and not halted.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_next     = ir;
    halted_next = halted_q;
    if (bus.run && !halted_q) begin
      unique case (state)
        T0: state_next = T1;
        T1: begin
          ir_next    = bus.bus_in;
          pc_next    = pc + PC_WIDTH'(1);
          state_next = T2;
        end
        T2: begin
          state_next = T0;
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: state_next = T3;
            OP_JMP: pc_next = bus.bus_in[PC_WIDTH-1:0];
            OP_HLT: halted_next = 1'b1;
            default: ;
          endcase
        end
        T3: state_next = (op == OP_ADD || op == OP_SUB) ? T4 : T0;
        T4: state_next = T0;
        default: state_next = T0;
      endcase
    end
  end

  // Output decode: strobes from (T-state, opcode), all gated by strobe_en.
  always_comb begin
    bus.pc_bus_enable     = 1'b0;
    bus.ir_operand_enable = 1'b0;
    bus.ram_load_mar_reg  = 1'b0;
    bus.ram_output_enable = 1'b0;
    bus.ram_write_enable  = 1'b0;
    bus.reg_a_load        = 1'b0;
    bus.reg_a_enable      = 1'b0;
    bus.reg_b_load        = 1'b0;
    bus.alu_enable        = 1'b0;
    bus.alu_subtract      = 1'b0;
    bus.out_load          = 1'b0;
    if (strobe_en) begin
      unique case (state)
        T0: begin
          bus.pc_bus_enable    = 1'b1;
          bus.ram_load_mar_reg = 1'b1;
        end
        T1: bus.ram_output_enable = 1'b1;
        T2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus.ir_operand_enable = 1'b1;
              bus.ram_load_mar_reg  = 1'b1;
            end
            OP_LDI: begin
              bus.ir_operand_enable = 1'b1;
              bus.reg_a_load        = 1'b1;
            end
            OP_JMP: bus.ir_operand_enable = 1'b1;
            OP_OUT: begin
              bus.reg_a_enable = 1'b1;
              bus.out_load     = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (op)
            OP_LDA: begin
              bus.ram_output_enable = 1'b1;
              bus.reg_a_load        = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus.ram_output_enable = 1'b1;
              bus.reg_b_load        = 1'b1;
            end
            OP_STA: begin
              bus.reg_a_enable     = 1'b1;
              bus.ram_write_enable = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            bus.alu_enable   = 1'b1;
            bus.reg_a_load   = 1'b1;
            bus.alu_subtract = (op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_bus_data     = DATA_WIDTH'(pc);
  assign bus.ir_operand_data = DATA_WIDTH'(ir[PC_WIDTH-1:0]);
  assign bus.opcode          = ir[7:4];
  assign bus.t_state         = state;
  assign bus.halted          = halted_q;

endmodule

// File: tb/tb_sap_u_control_unit.sv
// Self-checking bench for sap_u_control_unit against an instruction-level model.
module tb_sap_u_control_unit;

  localparam logic [10:0] M_PC_EN   = 11'h400;
  localparam logic [10:0] M_IR_EN   = 11'h200;
  localparam logic [10:0] M_MAR     = 11'h100;
  localparam logic [10:0] M_RAM_OE  = 11'h080;
  localparam logic [10:0] M_RAM_WE  = 11'h040;
  localparam logic [10:0] M_A_LD    = 11'h020;
  localparam logic [10:0] M_A_EN    = 11'h010;
  localparam logic [10:0] M_B_LD    = 11'h008;
  localparam logic [10:0] M_ALU_EN  = 11'h004;
  localparam logic [10:0] M_ALU_SUB = 11'h002;
  localparam logic [10:0] M_OUT_LD  = 11'h001;

  logic clk;
  logic reset;

  sap_u_control_unit_if #(.DATA_WIDTH(8)) bus_if ();

  sap_u_control_unit #(.PC_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: instruction-level view (PC, IR, step within instruction).
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  int         m_step;
  logic       m_halt;

  logic [10:0] obs_mask, exp_mask;
  logic [23:0] obs_st, exp_st;   // {t_state, pc_data, ir_data, opcode, halted}

  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [10:0] micro(input logic [3:0] op, input int step);
    if (step == 0) return M_PC_EN | M_MAR;
    if (step == 1) return M_RAM_OE;
    if (step == 2) begin
      case (op)
        4'h1, 4'h2, 4'h3, 4'h4: return M_IR_EN | M_MAR;
        4'h5: return M_IR_EN | M_A_LD;
        4'h6: return M_IR_EN;
        4'hE: return M_A_EN | M_OUT_LD;
        default: return '0;
      endcase
    end
    if (step == 3) begin
      case (op)
        4'h1: return M_RAM_OE | M_A_LD;
        4'h2, 4'h3: return M_RAM_OE | M_B_LD;
        4'h4: return M_A_EN | M_RAM_WE;
        default: return '0;
      endcase
    end
    case (op)
      4'h2: return M_ALU_EN | M_A_LD;
      4'h3: return M_ALU_EN | M_ALU_SUB | M_A_LD;
      default: return '0;
    endcase
  endfunction

  function automatic logic [9:0] stim(input logic r, input logic rs, input logic [7:0] b);
    return {r, rs, b};
  endfunction

  // One clock: drive inputs, capture DUT and model at negedge, advance both.
  task automatic exec(input logic r, input logic rs, input logic [7:0] b);
    bus_if.run    = r;
    reset         = rs;
    bus_if.bus_in = b;
    @(negedge clk);
    obs_mask = {bus_if.pc_bus_enable, bus_if.ir_operand_enable, bus_if.ram_load_mar_reg,
                bus_if.ram_output_enable, bus_if.ram_write_enable, bus_if.reg_a_load,
                bus_if.reg_a_enable, bus_if.reg_b_load, bus_if.alu_enable,
                bus_if.alu_subtract, bus_if.out_load};
    obs_st   = {bus_if.t_state, bus_if.pc_bus_data, bus_if.ir_operand_data,
                bus_if.opcode, bus_if.halted};
    exp_mask = (rs && r && !m_halt) ? micro(m_ir[7:4], m_step) : 11'h000;
    exp_st   = {3'(m_step), {4'h0, m_pc}, {4'h0, m_ir[3:0]}, m_ir[7:4], m_halt};
    @(posedge clk);
    #1;
    if (!rs) begin
      m_pc = '0; m_ir = '0; m_step = 0; m_halt = 1'b0;
    end else if (r && !m_halt) begin
      if (m_step == 0) m_step = 1;
      else if (m_step == 1) begin
        m_ir = b; m_pc = m_pc + 4'd1; m_step = 2;
      end else begin
        if (m_step == 2 && m_ir[7:4] == 4'h6) m_pc = b[3:0];
        if (m_step == 2 && m_ir[7:4] == 4'hF) m_halt = 1'b1;
        m_step = (m_step + 1 == instr_len(m_ir[7:4])) ? 0 : m_step + 1;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] q[$];
    logic [10:0] hm[$];
    logic [23:0] hs[$];
    q.push_back(stim(1, 0, 8'($urandom)));
    q.push_back(stim(1, 0, 8'($urandom)));
    q.push_back(stim(1, 1, 8'($urandom)));
    q.push_back(stim(1, 1, 8'h00));
    q.push_back(stim(1, 1, 8'($urandom)));
    foreach (q[i]) begin
      exec(q[i][9], q[i][8], q[i][7:0]);
      n_checks++;
      if (obs_mask !== exp_mask) begin
        n_fail++; $display("FAIL reset strobes cyc %0d: got %b want %b", i, obs_mask, exp_mask);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_fail++; $display("FAIL reset state cyc %0d: got %h want %h", i, obs_st, exp_st);
      end
      hm.push_back(obs_mask); hs.push_back(obs_st);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (hm[i] !== 11'h000 || hs[i] !== 24'h0) begin
        n_fail++; $display("FAIL reset_hold cyc %0d: got %b/%h want 0/0", i, hm[i], hs[i]);
      end
    end
    n_checks++;
    if (hm[2] !== (M_PC_EN | M_MAR)) begin
      n_fail++; $display("FAIL reset_release_t0: got %b want %b", hm[2], M_PC_EN | M_MAR);
    end
  endtask

  task automatic test_lda();
    logic [9:0] q[$];
    logic [10:0] hm[$];
    logic [23:0] hs[$];
    q.push_back(stim(1, 1, 8'($urandom)));
    q.push_back(stim(1, 1, 8'h1E));
    q.push_back(stim(1, 1, 8'($urandom)));
    q.push_back(stim(1, 1, 8'($urandom)));
    foreach (q[i]) begin
      exec(q[i][9], q[i][8], q[i][7:0]);
      n_checks++;
      if (obs_mask !== exp_mask) begin
        n_fail++; $display("FAIL lda strobes cyc %0d: got %b want %b", i, obs_mask, exp_mask);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_fail++; $display("FAIL lda state cyc %0d: got %h want %h", i, obs_st, exp_st);
      end
      hm.push_back(obs_mask); hs.push_back(obs_st);
    end
    n_checks++;
    if (hm[2] !== (M_IR_EN | M_MAR) || hs[2][12:5] !== 8'h0E) begin
      n_fail++; $display("FAIL lda_t2: got %b/%h want %b/0e", hm[2], hs[2][12:5], M_IR_EN | M_MAR);
    end
    n_checks++;
    if (hm[3] !== (M_RAM_OE | M_A_LD)) begin
      n_fail++; $display("FAIL lda_t3: got %b want %b", hm[3], M_RAM_OE | M_A_LD);
    end
    n_checks++;
    if (bus_if.t_state !== 3'd0 || bus_if.pc_bus_data !== 8'h02) begin
      n_fail++; $display("FAIL lda_next_t0: got t=%0d pc=%h want t=0 pc=02", bus_if.t_state, bus_if.pc_bus_data);
    end
  endtask

  task automatic test_sub();
    logic [9:0] q[$];
    logic [10:0] hm[$];
    q.push_back(stim(1, 1, 8'($urandom)));
    q.push_back(stim(1, 1, 8'h3F));
    for (int k = 0; k < 3; k++) q.push_back(stim(1, 1, 8'($urandom)));
    foreach (q[i]) begin
      exec(q[i][9], q[i][8], q[i][7:0]);
      n_checks++;
      if (obs_mask !== exp_mask) begin
        n_fail++; $display("FAIL sub strobes cyc %0d: got %b want %b", i, obs_mask, exp_mask);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_fail++; $display("FAIL sub state cyc %0d: got %h want %h", i, obs_st, exp_st);
      end
      hm.push_back(obs_mask);
    end
    n_checks++;
    if (hm[3] !== (M_RAM_OE | M_B_LD)) begin
      n_fail++; $display("FAIL sub_t3: got %b want %b", hm[3], M_RAM_OE | M_B_LD);
    end
    n_checks++;
    if (hm[4] !== (M_ALU_EN | M_ALU_SUB | M_A_LD)) begin
      n_fail++; $display("FAIL sub_t4: got %b want %b", hm[4], M_ALU_EN | M_ALU_SUB | M_A_LD);
    end
    n_checks++;
    if (bus_if.t_state !== 3'd0 || bus_if.pc_bus_data !== 8'h03) begin
      n_fail++; $display("FAIL sub_next_t0: got t=%0d pc=%h want t=0 pc=03", bus_if.t_state, bus_if.pc_bus_data);
    end
  endtask

  task automatic test_jmp();
    logic [9:0] q[$];
    logic [7:0] pcs[$];
    // JMP 5, JMP F, NOP at PC=15 (wraps to 0)
    logic [7:0] prog[3] = '{8'h65, 8'h6F, 8'h00};
    logic [7:0] tgt[3]  = '{8'h05, 8'h0F, 8'h00};
    for (int n = 0; n < 3; n++) begin
      q = {};
      q.push_back(stim(1, 1, 8'($urandom)));
      q.push_back(stim(1, 1, prog[n]));
      q.push_back(stim(1, 1, (n < 2) ? tgt[n] : 8'($urandom)));
      foreach (q[i]) begin
        exec(q[i][9], q[i][8], q[i][7:0]);
        n_checks++;
        if (obs_mask !== exp_mask) begin
          n_fail++; $display("FAIL jmp%0d strobes cyc %0d: got %b want %b", n, i, obs_mask, exp_mask);
        end
        n_checks++;
        if (obs_st !== exp_st) begin
          n_fail++; $display("FAIL jmp%0d state cyc %0d: got %h want %h", n, i, obs_st, exp_st);
        end
      end
      pcs.push_back(bus_if.pc_bus_data);
    end
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (pcs[n] !== tgt[n]) begin
        n_fail++; $display("FAIL jmp_pc%0d: got %h want %h", n, pcs[n], tgt[n]);
      end
    end
  endtask

  task automatic test_run_freeze();
    logic [9:0] q[$];
    logic [10:0] hm[$];
    logic [23:0] hs[$];
    q.push_back(stim(1, 1, 8'($urandom)));
    q.push_back(stim(1, 1, 8'h2A));
    q.push_back(stim(1, 1, 8'($urandom)));
    for (int k = 0; k < 3; k++) q.push_back(stim(0, 1, 8'($urandom)));
    q.push_back(stim(1, 1, 8'($urandom)));
    q.push_back(stim(1, 1, 8'($urandom)));
    foreach (q[i]) begin
      exec(q[i][9], q[i][8], q[i][7:0]);
      n_checks++;
      if (obs_mask !== exp_mask) begin
        n_fail++; $display("FAIL freeze strobes cyc %0d: got %b want %b", i, obs_mask, exp_mask);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_fail++; $display("FAIL freeze state cyc %0d: got %h want %h", i, obs_st, exp_st);
      end
      hm.push_back(obs_mask); hs.push_back(obs_st);
    end
    for (int i = 3; i < 6; i++) begin
      n_checks++;
      if (hm[i] !== 11'h000 || hs[i][23:21] !== 3'd3) begin
        n_fail++; $display("FAIL freeze_hold cyc %0d: got %b t=%0d want 0 t=3", i, hm[i], hs[i][23:21]);
      end
    end
    n_checks++;
    if (hm[6] !== (M_RAM_OE | M_B_LD) || hm[7] !== (M_ALU_EN | M_A_LD)) begin
      n_fail++; $display("FAIL freeze_resume: got %b,%b want %b,%b", hm[6], hm[7], M_RAM_OE | M_B_LD, M_ALU_EN | M_A_LD);
    end
  endtask

  task automatic test_random();
    logic r, rs;
    logic [7:0] b;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 63) != 0);
      b  = 8'($urandom);
      if (m_step == 1) b[7:4] = 4'($urandom_range(0, 14));
      exec(r, rs, b);
      n_checks++;
      if (obs_mask !== exp_mask) begin
        n_fail++; $display("FAIL rand strobes cyc %0d: got %b want %b", i, obs_mask, exp_mask);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_fail++; $display("FAIL rand state cyc %0d: got %h want %h", i, obs_st, exp_st);
      end
      n_checks++;
      if ($countones({obs_mask[10], obs_mask[9], obs_mask[7], obs_mask[4], obs_mask[2]}) > 1) begin
        n_fail++; $display("FAIL rand onehot cyc %0d: got %b want at most one bus driver", i, obs_mask);
      end
    end
  endtask

  task automatic test_halt();
    logic [9:0] q[$];
    logic [10:0] hm[$];
    logic [23:0] hs[$];
    q.push_back(stim(1, 0, 8'($urandom)));
    q.push_back(stim(1, 1, 8'($urandom)));
    q.push_back(stim(1, 1, 8'hF0));
    q.push_back(stim(1, 1, 8'($urandom)));
    for (int k = 0; k < 10; k++) q.push_back(stim(1'(k), 1, 8'($urandom)));
    q.push_back(stim(1, 0, 8'($urandom)));
    foreach (q[i]) begin
      exec(q[i][9], q[i][8], q[i][7:0]);
      n_checks++;
      if (obs_mask !== exp_mask) begin
        n_fail++; $display("FAIL halt strobes cyc %0d: got %b want %b", i, obs_mask, exp_mask);
      end
      n_checks++;
      if (obs_st !== exp_st) begin
        n_fail++; $display("FAIL halt state cyc %0d: got %h want %h", i, obs_st, exp_st);
      end
      hm.push_back(obs_mask); hs.push_back(obs_st);
    end
    for (int i = 4; i < 14; i++) begin
      n_checks++;
      if (hm[i] !== 11'h000 || hs[i] !== {3'd0, 8'h01, 8'h00, 4'hF, 1'b1}) begin
        n_fail++; $display("FAIL halt_hold cyc %0d: got %b/%h want 0/%h", i, hm[i], hs[i], {3'd0, 8'h01, 8'h00, 4'hF, 1'b1});
      end
    end
    n_checks++;
    if (bus_if.halted !== 1'b0 || bus_if.pc_bus_data !== 8'h00) begin
      n_fail++; $display("FAIL halt_exit: got halted=%b pc=%h want 0/00", bus_if.halted, bus_if.pc_bus_data);
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus_if.run    = 1'b0;
    bus_if.bus_in = '0;
    m_pc = '0; m_ir = '0; m_step = 0; m_halt = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lda();
    test_sub();
    test_jmp();
    test_run_freeze();
    test_random();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
